// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous-read memory port between the IF stage and a loader.
// Optional build macro IMEM_ADDR_CHECK_EN blocks out-of-range / misaligned accesses instead of wrapping.
module imem_arbiter #(
  parameter int DEPTH        = 256,
  parameter int MAX_LD_BURST = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_if_req,
  input  logic [31:0]              i_if_addr,
  output logic [31:0]              o_if_data,
  output logic                     o_if_valid,
  output logic                     o_stall_if,
  input  logic                     i_ld_req,
  input  logic                     i_ld_we,
  input  logic [31:0]              i_ld_addr,
  input  logic [31:0]              i_ld_wdata,
  output logic                     o_ld_gnt,
  output logic [31:0]              o_ld_rdata,
  output logic                     o_ld_rvalid,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [$clog2(DEPTH)-1:0] o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic [31:0]              i_mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_LD_BURST + 1);
  localparam logic [31:0] RESET_INSTR = 32'h0800_0000;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD} state_t;
  typedef enum logic [2:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_IF_BAD, OWN_LD_BAD} owner_t;

  state_t          w_state;
  owner_t          r_owner, w_owner_nxt;
  logic [BW-1:0]   r_burst;
  logic [31:0]     r_if_hold, r_ld_hold;
  logic            w_burst_full, w_if_gnt, w_ld_gnt, w_if_ok, w_ld_ok;
  logic [AW-1:0]   w_if_idx, w_ld_idx;
  logic            w_if_valid, w_ld_valid;
  logic [31:0]     w_if_rd, w_ld_rd;
  logic            w_unused;

  assign w_if_idx     = i_if_addr[AW+1:2];
  assign w_ld_idx     = i_ld_addr[AW+1:2];
  assign w_burst_full = (r_burst == BW'(MAX_LD_BURST));

`ifdef IMEM_ADDR_CHECK_EN
  assign w_if_ok = (i_if_addr[1:0] == 2'b00) && ({2'b00, i_if_addr[31:2]} < 32'(DEPTH));
  assign w_ld_ok = (i_ld_addr[1:0] == 2'b00) && ({2'b00, i_ld_addr[31:2]} < 32'(DEPTH));
`else
  assign w_if_ok = 1'b1;
  assign w_ld_ok = 1'b1;
`endif

  // Bits outside the word index only matter when the address check is built in.
  assign w_unused = ^{i_if_addr[31:AW+2], i_if_addr[1:0], i_ld_addr[31:AW+2], i_ld_addr[1:0]};

  // Grant is decided combinationally so the memory samples it on the same edge.
  always_comb begin
    w_state = S_IDLE;
    if (i_reset) begin
      if (i_ld_req && !(i_if_req && w_burst_full)) w_state = S_LOAD;
      else if (i_if_req)                           w_state = S_FETCH;
    end
  end

  assign w_if_gnt = (w_state == S_FETCH);
  assign w_ld_gnt = (w_state == S_LOAD);

  assign o_ld_gnt    = w_ld_gnt;
  assign o_stall_if  = i_reset && i_if_req && !w_if_gnt;
  assign o_mem_en    = (w_if_gnt && w_if_ok) || (w_ld_gnt && w_ld_ok);
  assign o_mem_we    = w_ld_gnt && i_ld_we && w_ld_ok;
  assign o_mem_addr  = w_ld_gnt ? w_ld_idx : w_if_idx;
  assign o_mem_wdata = i_ld_wdata;

  always_comb begin
    w_owner_nxt = OWN_NONE;
    case (w_state)
      S_FETCH: w_owner_nxt = w_if_ok ? OWN_IF : OWN_IF_BAD;
      S_LOAD:  if (!i_ld_we) w_owner_nxt = w_ld_ok ? OWN_LD : OWN_LD_BAD;
      default: w_owner_nxt = OWN_NONE;
    endcase
  end

  // Blocked fetches return a jump-to-0; blocked loader reads return zero.
  assign w_if_valid = i_reset && ((r_owner == OWN_IF) || (r_owner == OWN_IF_BAD));
  assign w_ld_valid = i_reset && ((r_owner == OWN_LD) || (r_owner == OWN_LD_BAD));
  assign w_if_rd    = (r_owner == OWN_IF) ? i_mem_rdata : RESET_INSTR;
  assign w_ld_rd    = (r_owner == OWN_LD) ? i_mem_rdata : 32'h0;

  assign o_if_valid  = w_if_valid;
  assign o_ld_rvalid = w_ld_valid;
  assign o_if_data   = !i_reset ? RESET_INSTR : (w_if_valid ? w_if_rd : r_if_hold);
  assign o_ld_rdata  = !i_reset ? 32'h0       : (w_ld_valid ? w_ld_rd : r_ld_hold);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_owner   <= OWN_NONE;
      r_burst   <= '0;
      r_if_hold <= RESET_INSTR;
      r_ld_hold <= 32'h0;
    end else begin
      r_owner <= w_owner_nxt;
      if (w_if_valid) r_if_hold <= w_if_rd;
      if (w_ld_valid) r_ld_hold <= w_ld_rd;
      if (!i_if_req || w_if_gnt)            r_burst <= '0;
      else if (w_ld_gnt && !w_burst_full)   r_burst <= r_burst + BW'(1);
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory depth in words; word index is addr[9:2] at default.
REQ-002 Parameter MAX_LD_BURST, default 4, maximum consecutive loader grants while fetch is waiting.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 if_req  input  1  IF stage requests an instruction word this cycle.
REQ-006 if_addr  input  32  IF stage PC (byte address).
REQ-007 if_data  output  32  fetched instruction.
REQ-008 if_valid  output  1  if_data valid this cycle.
REQ-009 stall_if  output  1  IF request not granted this cycle; PC must hold.
REQ-010 ld_req  input  1  loader (UART boot / debug) requests memory access.
REQ-011 ld_we  input  1  loader access is a write.
REQ-012 ld_addr  input  32  loader byte address.
REQ-013 ld_wdata  input  32  loader write data.
REQ-014 ld_gnt  output  1  loader access accepted this cycle.
REQ-015 ld_rdata  output  32  loader read data.
REQ-016 ld_rvalid  output  1  ld_rdata valid this cycle.
REQ-017 mem_en, mem_we  output  1 each  memory enable / write enable.
REQ-018 mem_addr  output  log2(DEPTH)  memory word index.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data, one-cycle synchronous read latency.

Function
REQ-021 At most one memory access is issued per cycle; mem_en high only on the cycle a requester is granted.
REQ-022 Arbiter states: IDLE (no grant), FETCH (if granted), LOAD (ld granted); state is recomputed every cycle.
REQ-023 Loader has priority over fetch, except when the burst counter equals MAX_LD_BURST and if_req is high: fetch is granted, counter clears.
REQ-024 Burst counter increments on each ld grant while if_req is high; clears on any fetch grant or any cycle with if_req low; saturates at MAX_LD_BURST.
REQ-025 stall_if = if_req AND NOT fetch-granted, combinational in the same cycle.
REQ-026 Read data returns exactly one cycle after grant: if_valid (fetch) or ld_rvalid (loader read) pulses for one cycle with mem_rdata routed to the owner recorded in a one-entry owner register.
REQ-027 Loader writes produce no ld_rvalid; write completes on grant cycle.
REQ-028 Back-to-back grants pipeline fully: grant every cycle, data every cycle, no bubbles.
REQ-029 Simultaneous ld write and fetch of the same word: write wins the cycle; subsequent fetch returns new data.
REQ-030 Outputs if_data and ld_rdata hold last valid value when their valid is low.

Reset
REQ-031 While reset low: state IDLE, burst counter 0, owner register empty, mem_en/mem_we/if_valid/ld_rvalid/ld_gnt 0, if_data 32'h0800_0000, ld_rdata 0, stall_if 0.
REQ-032 Reset asserted mid-access discards the outstanding read; no valid pulse follows.
REQ-033 First grant possible on the first rising edge after reset deasserts.

Configuration
REQ-034 Macro IMEM_ADDR_CHECK_EN: when defined, a fetch with if_addr[1:0]!=0 or word index >= DEPTH is not issued to memory; one cycle later if_valid pulses with if_data 32'h0800_0000 (j 0); such loader accesses get ld_gnt but writes are dropped and reads return 0.
REQ-035 Without IMEM_ADDR_CHECK_EN: address bits above the word index and [1:0] are ignored; all accesses reach memory (wrap-around).

Verification
REQ-036 Fetch only, if_req=1, PC 0,4,8 consecutive -> mem_addr 0,1,2 consecutive cycles, if_valid each following cycle, stall_if always 0.
REQ-037 ld_req=1 writes continuous, if_req=1 -> ld_gnt 4 cycles, fetch granted 5th cycle, pattern repeats; stall_if high exactly 4 of every 5 cycles.
REQ-038 Loader writes 32'h0C00_0051 to word 3, then fetch addr 12 -> if_data 32'h0C00_0051.
REQ-039 Loader read granted, reset low next cycle -> ld_rvalid stays 0; all outputs at reset values.
REQ-040 With IMEM_ADDR_CHECK_EN, fetch addr 0x402 -> no mem_en, if_valid next cycle with 32'h0800_0000; without macro, fetch addr 0x400 -> mem_addr 0.
